// File: rtl/imem_fetch_ctrl_if.sv
// Fetch controller bus: instruction-memory port, redirect input and decode handshake.
// The perf counter signals exist only when FETCH_PERF_EN is defined.
interface imem_fetch_ctrl_if;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic        out_fault;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_stall;

  modport master (
    output imem_addr, input imem_instr, input redirect_valid, input redirect_pc,
    output out_valid, input out_ready, output out_pc, output out_instr, output out_fault,
    output perf_fetched, output perf_stall
  );
  modport slave (
    input imem_addr, output imem_instr, output redirect_valid, output redirect_pc,
    input out_valid, output out_ready, input out_pc, input out_instr, input out_fault,
    input perf_fetched, input perf_stall
  );
`else
  modport master (
    output imem_addr, input imem_instr, input redirect_valid, input redirect_pc,
    output out_valid, input out_ready, output out_pc, output out_instr, output out_fault
  );
  modport slave (
    input imem_addr, output imem_instr, output redirect_valid, output redirect_pc,
    input out_valid, output out_ready, input out_pc, input out_instr, input out_fault
  );
`endif
endinterface

// File: rtl/imem_fetch_ctrl.sv
// Instruction fetch sequencer: owns the PC, tracks the one-cycle memory read, buffers words
// for decode, handles redirects and address faults. FETCH_PERF_EN adds fetch/stall counters.
module imem_fetch_ctrl #(
  parameter logic [31:0] RESET_PC   = 32'h0100_0000,
  parameter logic [31:0] IMEM_BASE  = 32'h0100_0000,
  parameter int          IMEM_SIZE  = 2048,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  imem_fetch_ctrl_if.master bus
);
  localparam int          PW        = $clog2(FIFO_DEPTH);
  localparam int          CW        = PW + 1;
  localparam logic [31:0] IMEM_LAST = IMEM_BASE + 32'(IMEM_SIZE) - 32'd4;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [0:0] {ST_FETCH = 1'b0, ST_HALT = 1'b1} state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        fault;
  } entry_t;

  function automatic logic addr_legal(input logic [31:0] addr);
    return (addr[1:0] == 2'b00) && (addr >= IMEM_BASE) && (addr <= IMEM_LAST);
  endfunction

  state_t        state_r, state_nxt_s;
  logic [31:0]   imem_addr_r;
  logic          d_v_r;
  logic [31:0]   d_pc_r;
  entry_t        fifo_mem_r [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr_r, wr_ptr_r;
  logic [CW-1:0] count_r;
  logic [CW:0]   occ_s;
  logic          out_valid_s, pop_s, room_s, a_v_s, fault_push_s, push_s;
  entry_t        head_s, push_entry_s;

  assign out_valid_s = (count_r != {CW{1'b0}});
  assign pop_s       = out_valid_s && bus.out_ready;
  assign head_s      = fifo_mem_r[rd_ptr_r];
  // Entries already buffered (after this cycle's pop) plus the word returning now
  assign occ_s       = (CW+1)'(count_r) - (CW+1)'(pop_s) + (CW+1)'(d_v_r);
  assign room_s      = (occ_s < (CW+1)'(FIFO_DEPTH));

  // Issue/fault decision and selection of the word entering the buffer
  always_comb begin
    a_v_s        = 1'b0;
    fault_push_s = 1'b0;
    push_s       = 1'b0;
    push_entry_s = '{pc: d_pc_r, instr: bus.imem_instr, fault: 1'b0};
    if (bus.redirect_valid) begin
      push_s = 1'b0;
    end else begin
      if ((state_r == ST_FETCH) && room_s) begin
        if (addr_legal(imem_addr_r)) begin
          a_v_s = 1'b1;
        end else if (!d_v_r) begin
          fault_push_s = 1'b1;
        end else begin
          fault_push_s = 1'b0;
        end
      end else begin
        a_v_s = 1'b0;
      end
      // A returning word always goes first; the fault entry waits until nothing is in flight
      if (d_v_r) begin
        push_s = 1'b1;
      end else if (fault_push_s) begin
        push_s       = 1'b1;
        push_entry_s = '{pc: imem_addr_r, instr: NOP_INSTR, fault: 1'b1};
      end else begin
        push_s = 1'b0;
      end
    end
  end

  // Next-state logic: a fault halts fetch until a redirect
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_FETCH: begin
        if (bus.redirect_valid)  state_nxt_s = ST_FETCH;
        else if (fault_push_s)   state_nxt_s = ST_HALT;
        else                     state_nxt_s = ST_FETCH;
      end
      ST_HALT: begin
        if (bus.redirect_valid)  state_nxt_s = ST_FETCH;
        else                     state_nxt_s = ST_HALT;
      end
      default: state_nxt_s = ST_FETCH;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_r <= ST_FETCH;
    else     state_r <= state_nxt_s;
  end

  // PC, in-flight read tracking and buffer pointers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      imem_addr_r <= RESET_PC;
      d_v_r       <= 1'b0;
      d_pc_r      <= 32'h0000_0000;
      rd_ptr_r    <= {PW{1'b0}};
      wr_ptr_r    <= {PW{1'b0}};
      count_r     <= {CW{1'b0}};
    end else if (bus.redirect_valid) begin
      imem_addr_r <= bus.redirect_pc;
      d_v_r       <= 1'b0;
      d_pc_r      <= imem_addr_r;
      rd_ptr_r    <= {PW{1'b0}};
      wr_ptr_r    <= {PW{1'b0}};
      count_r     <= {CW{1'b0}};
    end else begin
      d_v_r  <= a_v_s;
      d_pc_r <= imem_addr_r;
      if (a_v_s)  imem_addr_r <= imem_addr_r + 32'd4;
      if (push_s) wr_ptr_r    <= wr_ptr_r + PW'(1);
      if (pop_s)  rd_ptr_r    <= rd_ptr_r + PW'(1);
      count_r <= count_r + CW'(push_s) - CW'(pop_s);
    end
  end

  // Buffer storage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_mem_r[i] <= '{pc: 32'h0, instr: 32'h0, fault: 1'b0};
    end else if (push_s) begin
      fifo_mem_r[wr_ptr_r] <= push_entry_s;
    end
  end

  assign bus.imem_addr = imem_addr_r;
  assign bus.out_valid = out_valid_s;
  assign bus.out_pc    = out_valid_s ? head_s.pc    : 32'h0000_0000;
  assign bus.out_instr = out_valid_s ? head_s.instr : 32'h0000_0000;
  assign bus.out_fault = out_valid_s ? head_s.fault : 1'b0;

`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched_r, perf_stall_r;

  // Accepted good words and empty-buffer cycles while fetching; redirects do not clear them
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_fetched_r <= 32'h0000_0000;
      perf_stall_r   <= 32'h0000_0000;
    end else begin
      if (pop_s && !head_s.fault)                 perf_fetched_r <= perf_fetched_r + 32'd1;
      if (!out_valid_s && (state_r == ST_FETCH))  perf_stall_r   <= perf_stall_r + 32'd1;
    end
  end

  assign bus.perf_fetched = perf_fetched_r;
  assign bus.perf_stall   = perf_stall_r;
`endif
endmodule
